fpu_add_subt_issuer: RTL
========================

FPU_ADD_SUBT_ISSUER -- requirements
Module: fpu_add_subt_issuer

Interface
REQ-001 SHALL have parameter W, default 64, giving the IEEE-754 word width (32 or 64).
REQ-002 SHALL have parameter TMO, default 255, giving the maximum number of cycles waited for fpu_ready, range 2..65535.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  host operand request.
REQ-006 SHALL have port in_ready  out  1  issuer accepts a request.
REQ-007 SHALL have port in_x  in  W  operand X.
REQ-008 SHALL have port in_y  in  W  operand Y.
REQ-009 SHALL have port in_op  in  1  operation select: 0 = add, 1 = subtract.
REQ-010 SHALL have port in_rmode  in  2  rounding mode.
REQ-011 SHALL have port out_valid  out  1  result available.
REQ-012 SHALL have port out_ready  in  1  host accepts the result.
REQ-013 SHALL have port out_result  out  W  captured IEEE-754 result.
REQ-014 SHALL have port out_ovf  out  1  captured overflow flag.
REQ-015 SHALL have port out_unf  out  1  captured underflow flag.
REQ-016 SHALL have port out_tmo  out  1  result invalid because the wait timed out.
REQ-017 SHALL have port op_count  out  16  count of completed transactions.
REQ-018 SHALL have port Data_X  out  W  operand X to the FPU.
REQ-019 SHALL have port Data_Y  out  W  operand Y to the FPU.
REQ-020 SHALL have port add_subt  out  1  operation select to the FPU.
REQ-021 SHALL have port r_mode  out  2  rounding mode to the FPU.
REQ-022 SHALL have port beg_FSM  out  1  FPU start pulse.
REQ-023 SHALL have port ack_FSM  out  1  FPU acknowledge pulse.
REQ-024 SHALL have port fpu_ready  in  1  FPU done; held high until acknowledged.
REQ-025 SHALL have port fpu_result  in  W  FPU final_result_ieee.
REQ-026 SHALL have port fpu_ovf  in  1  FPU overflow_flag.
REQ-027 SHALL have port fpu_unf  in  1  FPU underflow_flag.

Function
REQ-028 SHALL implement states IDLE, LAUNCH, WAIT, ACK and RESP, with IDLE as the reset state.
REQ-029 SHALL drive in_ready = 1 only in IDLE; in IDLE, in_valid = 1 SHALL latch in_x, in_y, in_op and in_rmode into the Data_X, Data_Y, add_subt and r_mode registers and move to LAUNCH.
REQ-030 SHALL hold Data_X, Data_Y, add_subt and r_mode stable from the accept edge until the next accept.
REQ-031 SHALL assert beg_FSM for exactly one cycle, in LAUNCH, then move to WAIT and clear the wait counter.
REQ-032 In WAIT, SHALL increment a 16-bit wait counter each cycle while fpu_ready = 0.
REQ-033 In WAIT, fpu_ready = 1 SHALL capture fpu_result, fpu_ovf and fpu_unf into the out_* registers, clear out_tmo and move to ACK.
REQ-034 In WAIT, when fpu_ready = 0 and the counter equals TMO-1, SHALL load out_result = 0, out_ovf = 0, out_unf = 0, out_tmo = 1 and move to ACK.
REQ-035 SHALL give fpu_ready priority over timeout when both occur in the same cycle.
REQ-036 SHALL assert ack_FSM for exactly one cycle, in ACK, then move to RESP; this also resets the FPU's internal state after a timeout.
REQ-037 SHALL assert out_valid only in RESP and hold out_* stable until out_ready = 1.
REQ-038 In RESP, out_ready = 1 SHALL return the block to IDLE and increment op_count by 1, wrapping from 16'hFFFF to 0.
REQ-039 SHALL NOT accept a new request before the RESP handshake completes; in_ready is 0 in RESP even when out_ready = 1.
REQ-040 Back-to-back minimum latency SHALL be: accept edge -> beg_FSM next cycle; fpu_ready sampled -> ack_FSM next cycle -> out_valid the cycle after.
REQ-041 SHALL ignore fpu_ready outside WAIT.
REQ-042 SHALL ignore in_valid outside IDLE.

Reset
REQ-043 While rst = 0, SHALL immediately force state IDLE, in_ready = 1, and beg_FSM, ack_FSM, out_valid, out_tmo, out_ovf and out_unf = 0.
REQ-044 While rst = 0, SHALL force out_result, Data_X, Data_Y, add_subt, r_mode, op_count and the wait counter to 0.
REQ-045 Reset asserted mid-transaction SHALL abort without issuing ack_FSM; the FPU is reset by its own reset.

Verification
REQ-046 Accept in_x = 64'h3FF0000000000000, in_y = 64'h4000000000000000, in_op = 0; FPU model returns fpu_ready after 10 cycles with 64'h4008000000000000 -> one beg_FSM pulse, one ack_FSM pulse, out_result = 64'h4008000000000000, out_tmo = 0, op_count = 1.
REQ-047 TMO = 4, FPU never raises fpu_ready -> out_tmo = 1, out_result = 0, ack_FSM pulses once, and out_valid rises 6 cycles after beg_FSM.
REQ-048 Hold out_ready = 0 for 20 cycles in RESP -> out_* stable, in_ready = 0, and in_valid pulses ignored throughout.
REQ-049 fpu_ready and the timeout coincide at counter TMO-1 -> result captured and out_tmo = 0.
REQ-050 Deassert rst during WAIT -> all outputs at reset values asynchronously; after release, a new request completes normally.
REQ-051 Preload op_count = 16'hFFFF via 65535 transactions, or force it, then complete one transaction -> op_count = 0.

Source files
------------

// File: rtl/fpu_add_subt_issuer_if.sv
// fpu_add_subt_issuer_if: host request/response channel of the add/subtract issuer.
// master = host (drives requests, accepts results), slave = issuer.
// Request:  in_valid/in_ready handshake carrying in_x, in_y, in_op, in_rmode.
// Response: out_valid/out_ready handshake carrying out_result, out_ovf, out_unf, out_tmo.
interface fpu_add_subt_issuer_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_op;
    logic [1:0]   in_rmode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_ovf;
    logic         out_unf;
    logic         out_tmo;

    modport master (
        output in_valid, in_x, in_y, in_op, in_rmode, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_tmo
    );

    modport slave (
        input  in_valid, in_x, in_y, in_op, in_rmode, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_tmo
    );
endinterface

// File: rtl/fpu_add_subt_issuer.sv
// fpu_add_subt_issuer: issues one add/subtract to the FPU per host request and returns the result.
// Ports: clk, rst (async, active-low); host (request/response channel, slave side);
// op_count (completed transactions); Data_X, Data_Y, add_subt, r_mode, beg_FSM, ack_FSM (to FPU);
// fpu_ready, fpu_result, fpu_ovf, fpu_unf (from FPU).
module fpu_add_subt_issuer #(
    parameter int W   = 64,
    parameter int TMO = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_add_subt_issuer_if.slave  host,
    output logic [15:0]           op_count,
    output logic [W-1:0]          Data_X,
    output logic [W-1:0]          Data_Y,
    output logic                  add_subt,
    output logic [1:0]            r_mode,
    output logic                  beg_FSM,
    output logic                  ack_FSM,
    input  logic                  fpu_ready,
    input  logic [W-1:0]          fpu_result,
    input  logic                  fpu_ovf,
    input  logic                  fpu_unf
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACK, RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    state_t       state, state_d;
    logic [15:0]  wait_cnt;
    logic [W-1:0] res_q;
    logic         ovf_q, unf_q, tmo_q;
    logic         in_ready_c, out_valid_c, tmo_hit;

    assign tmo_hit = wait_cnt == TMO_LAST;

    always_comb begin
        state_d     = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        beg_FSM     = 1'b0;
        ack_FSM     = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                state_d    = host.in_valid ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                beg_FSM = 1'b1;
                state_d = WAIT;
            end
            // a ready FPU wins over a coinciding timeout: both exit to ACK,
            // the datapath below decides which values are captured
            WAIT:    state_d = (fpu_ready || tmo_hit) ? ACK : WAIT;
            ACK: begin
                ack_FSM = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                out_valid_c = 1'b1;
                state_d     = host.out_ready ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            op_count <= '0;
            Data_X   <= '0;
            Data_Y   <= '0;
            add_subt <= 1'b0;
            r_mode   <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && host.in_valid) begin
                Data_X   <= host.in_x;
                Data_Y   <= host.in_y;
                add_subt <= host.in_op;
                r_mode   <= host.in_rmode;
            end
            if (state == LAUNCH)
                wait_cnt <= '0;
            if (state == WAIT) begin
                if (fpu_ready) begin
                    res_q <= fpu_result;
                    ovf_q <= fpu_ovf;
                    unf_q <= fpu_unf;
                    tmo_q <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (tmo_hit) begin
                        res_q <= '0;
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
                        tmo_q <= 1'b1;
                    end
                end
            end
            if (state == RESP && host.out_ready)
                op_count <= op_count + 16'd1;
        end
    end

    assign host.in_ready   = in_ready_c;
    assign host.out_valid  = out_valid_c;
    assign host.out_result = res_q;
    assign host.out_ovf    = ovf_q;
    assign host.out_unf    = unf_q;
    assign host.out_tmo    = tmo_q;
endmodule
